// File: rtl/mips_bus_lsu_arbiter.sv
// mips_bus_lsu_arbiter
// Avalon-MM master shared by the instruction-fetch port and the load/store
// port. One access at a time: IDLE picks a winner, BUS runs the Avalon
// cycle, RESP returns a one-cycle ready pulse to the owner. Byte lanes,
// write-data replication, load extraction, misalignment and an optional
// waitrequest timeout are handled here so the core sees word-agnostic ports.

module mips_bus_lsu_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_PRIORITY = 1,
  parameter int TIMEOUT       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [31:0]       fetch_rdata,
  output logic              fetch_err,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [1:0]        data_size,
  input  logic              data_signed,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_ready,
  output logic [31:0]       data_rdata,
  output logic              data_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen on the edge of the last permitted stall cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic TIMEOUT_EN = (TIMEOUT > 0);
  localparam logic DATA_FIRST = (DATA_PRIORITY != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Size 11 and any access not on its natural boundary is rejected.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is right-justified by the core; copy it onto every lane so
  // byteenable alone selects what the slave writes.
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] rep;
    case (size)
      2'b00:   rep = {4{wd[7:0]}};
      2'b01:   rep = {2{wd[15:0]}};
      default: rep = wd;
    endcase
    return rep;
  endfunction

  // Little-endian lane extraction with optional sign extension.
  function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rd >> {lane, 3'b000};
    case (size)
      2'b00:   res = {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   res = {{16{sgn & sh[15]}}, sh[15:0]};
      default: res = rd;
    endcase
    return res;
  endfunction

  state_t            state_r, state_s;
  logic              owner_r, owner_s;     // 1 = data port owns the bus
  logic [1:0]        size_r, size_s;
  logic              signed_r, signed_s;
  logic [1:0]        lane_r, lane_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [ADDR_W-1:0] address_s;
  logic              read_s, write_s;
  logic [31:0]       writedata_s;
  logic [3:0]        byteenable_s;
  logic              fetch_ready_s, fetch_err_s, data_ready_s, data_err_s;
  logic [31:0]       fetch_rdata_s, data_rdata_s;

  // State register and every output register; reset leaves the bus quiet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      owner_r     <= 1'b0;
      size_r      <= 2'b00;
      signed_r    <= 1'b0;
      lane_r      <= 2'b00;
      cnt_r       <= {CNT_W{1'b0}};
      address     <= {ADDR_W{1'b0}};
      read        <= 1'b0;
      write       <= 1'b0;
      writedata   <= 32'h0000_0000;
      byteenable  <= 4'b0000;
      fetch_ready <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_rdata <= 32'h0000_0000;
      data_ready  <= 1'b0;
      data_err    <= 1'b0;
      data_rdata  <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      size_r      <= size_s;
      signed_r    <= signed_s;
      lane_r      <= lane_s;
      cnt_r       <= cnt_s;
      address     <= address_s;
      read        <= read_s;
      write       <= write_s;
      writedata   <= writedata_s;
      byteenable  <= byteenable_s;
      fetch_ready <= fetch_ready_s;
      fetch_err   <= fetch_err_s;
      fetch_rdata <= fetch_rdata_s;
      data_ready  <= data_ready_s;
      data_err    <= data_err_s;
      data_rdata  <= data_rdata_s;
    end
  end

  // Next state and next register values; responses default to idle zeros.
  always_comb begin
    state_s       = state_r;
    owner_s       = owner_r;
    size_s        = size_r;
    signed_s      = signed_r;
    lane_s        = lane_r;
    cnt_s         = cnt_r;
    address_s     = address;
    read_s        = read;
    write_s       = write;
    writedata_s   = writedata;
    byteenable_s  = byteenable;
    fetch_ready_s = 1'b0;
    fetch_err_s   = 1'b0;
    fetch_rdata_s = 32'h0000_0000;
    data_ready_s  = 1'b0;
    data_err_s    = 1'b0;
    data_rdata_s  = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (data_req && (!fetch_req || DATA_FIRST)) begin
          owner_s  = 1'b1;
          size_s   = data_size;
          signed_s = data_signed;
          lane_s   = data_addr[1:0];
          if (misaligned(data_size, data_addr[1:0])) begin
            data_ready_s = 1'b1;
            data_err_s   = 1'b1;
            state_s      = ST_RESP;
          end else begin
            address_s    = {data_addr[ADDR_W-1:2], 2'b00};
            read_s       = ~data_we;
            write_s      = data_we;
            byteenable_s = lane_enables(data_size, data_addr[1:0]);
            writedata_s  = lane_replicate(data_size, data_wdata);
            cnt_s        = {CNT_W{1'b0}};
            state_s      = ST_BUS;
          end
        end else if (fetch_req) begin
          owner_s = 1'b0;
          if (fetch_addr[1:0] != 2'b00) begin
            fetch_ready_s = 1'b1;
            fetch_err_s   = 1'b1;
            state_s       = ST_RESP;
          end else begin
            address_s    = {fetch_addr[ADDR_W-1:2], 2'b00};
            read_s       = 1'b1;
            write_s      = 1'b0;
            byteenable_s = 4'b1111;
            cnt_s        = {CNT_W{1'b0}};
            state_s      = ST_BUS;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (!waitrequest) begin
          read_s  = 1'b0;
          write_s = 1'b0;
          state_s = ST_RESP;
          if (owner_r) begin
            data_ready_s = 1'b1;
            data_rdata_s = write ? 32'h0000_0000 : load_extract(readdata, size_r, lane_r, signed_r);
          end else begin
            fetch_ready_s = 1'b1;
            fetch_rdata_s = readdata;
          end
        end else if (TIMEOUT_EN && (cnt_r == CNT_LAST)) begin
          // Slave stalled too long: abandon the cycle and report an error.
          read_s  = 1'b0;
          write_s = 1'b0;
          state_s = ST_RESP;
          if (owner_r) begin
            data_ready_s = 1'b1;
            data_err_s   = 1'b1;
          end else begin
            fetch_ready_s = 1'b1;
            fetch_err_s   = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        read_s  = 1'b0;
        write_s = 1'b0;
      end
    endcase
  end

endmodule
